// File: rtl/button_conditioner.sv
// Multi-channel button/switch conditioner: two-flop synchronizer, stable-count
// debounce and per-channel auto-repeat, all outputs registered.
module button_conditioner #(
    parameter int NUM_CH          = 8,
    parameter int DEBOUNCE_CYCLES = 400_000,
    parameter int REPEAT_DELAY    = 20_000_000,
    parameter int REPEAT_PERIOD   = 4_000_000
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic [NUM_CH-1:0] pins_i,
    output logic [NUM_CH-1:0] level_o,
    output logic [NUM_CH-1:0] press_o,
    output logic [NUM_CH-1:0] release_o,
    output logic [NUM_CH-1:0] repeat_p_o
);

    localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RC_W   = (RC_MAX > 1) ? $clog2(RC_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RC_W-1:0]  DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
    localparam logic [RC_W-1:0]  PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);
    localparam bit               REPEAT_EN   = (REPEAT_DELAY != 0);

    typedef enum logic [1:0] {
        RPT_OFF,
        RPT_DELAY,
        RPT_PERIOD
    } rpt_state_e;

    logic [NUM_CH-1:0] sync1_q;
    logic [NUM_CH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync1_q <= '0;
            sync_q  <= '0;
        end else begin
            sync1_q <= pins_i;
            sync_q  <= sync1_q;
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [RC_W-1:0]  rc_q, rc_d;
        rpt_state_e       state_q, state_d;
        logic             level_q, level_d;
        logic             press_q, press_d;
        logic             release_q, release_d;
        logic             repeat_q, repeat_d;

        always_comb begin
            cnt_d     = cnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            repeat_d  = 1'b0;
            state_d   = state_q;
            rc_d      = rc_q;

            // Any sample agreeing with the accepted level restarts the stable count.
            if (sync_q[ch] == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_d     = '0;
                level_d   = sync_q[ch];
                press_d   = sync_q[ch];
                release_d = !sync_q[ch];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end

            // A release suppresses any repeat that would fall on the same edge.
            if (press_d) begin
                state_d = REPEAT_EN ? RPT_DELAY : RPT_OFF;
                rc_d    = '0;
            end else if (release_d || !level_q) begin
                state_d = RPT_OFF;
                rc_d    = '0;
            end else begin
                case (state_q)
                    RPT_DELAY: begin
                        if (rc_q == DELAY_LAST) begin
                            repeat_d = 1'b1;
                            rc_d     = '0;
                            state_d  = RPT_PERIOD;
                        end else begin
                            rc_d = rc_q + 1'b1;
                        end
                    end
                    RPT_PERIOD: begin
                        if (rc_q == PERIOD_LAST) begin
                            repeat_d = 1'b1;
                            rc_d     = '0;
                        end else begin
                            rc_d = rc_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = RPT_OFF;
                        rc_d    = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                cnt_q     <= '0;
                rc_q      <= '0;
                state_q   <= RPT_OFF;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                cnt_q     <= cnt_d;
                rc_q      <= rc_d;
                state_q   <= state_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                repeat_q  <= repeat_d;
            end
        end

        assign level_o[ch]    = level_q;
        assign press_o[ch]    = press_q;
        assign release_o[ch]  = release_q;
        assign repeat_p_o[ch] = repeat_q;
    end

endmodule
